square_motion: RTL and testbench
================================

Name: square_motion

Overview:
- Converts the square's speed magnitudes (sq_xvel, sq_yvel, in pixels/second) into per-frame integer pixel steps, and integrates those steps into the square's screen position.
- Keeps a fractional remainder so that the average speed over time is exact.
- Handles top/bottom wall reflection, paddle-driven X reversal, out-of-bounds miss detection, and re-serve from centre.
- Sits directly downstream of the velocity mapper. Upstream of the renderer and the collision/score logic.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- SQ_SIZE, 16, square side in pixels
- FRAME_RATE, 60, frames/second; divisor for the px/s to px/frame conversion
- X_START, 312, serve X (top-left corner)
- Y_START, 232, serve Y (top-left corner)

Ports:
- clk_0  in  1  25.175MHz pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame (end of active video)
- sq_xvel  in  9  X speed magnitude, px/s
- sq_yvel  in  9  Y speed magnitude, px/s
- pdl_bounce  in  1  one-cycle pulse; paddle hit, reverse X direction
- serve  in  1  level; launch the square from WAIT_SERVE
- freeze  in  1  level; game over or startup menu, park the square
- sq_x  out  10  square top-left X
- sq_y  out  10  square top-left Y
- sq_xdir  out  1  1 = moving right
- sq_ydir  out  1  1 = moving down
- sq_missed  out  1  one-cycle pulse when the square leaves via left or right
- miss_side  out  1  0 = left exit, 1 = right exit; held until next miss
- busy  out  1  high while a frame update is in progress

Behaviour:
- Reset (async, rst=1):
  - sq_x=X_START, sq_y=Y_START
  - sq_xdir=1, sq_ydir=1, sq_missed=0, miss_side=1, busy=0
  - remainders rem_x=rem_y=0, bounce_pend=0
  - state=WAIT_SERVE
- State IDLE: on frame_tick with freeze=0, go to ACC and set busy=1.
- State ACC (1 cycle):
  - sum_x = rem_x + sq_xvel, sum_y = rem_y + sq_yvel; both 10-bit, max 570.
  - q_x = q_y = 0 (4-bit step counters). Go to DIV.
- State DIV (one cycle per iteration):
  - Each cycle, for each axis independently: if sum >= FRAME_RATE, then sum -= FRAME_RATE and q += 1.
  - Exit to MOVE in the first cycle where both sums < FRAME_RATE. That exit cycle does no subtraction.
  - Duration is max(q_x, q_y)+1 cycles; max q is 9.
- State MOVE (1 cycle):
  - rem_x=sum_x, rem_y=sum_y.
  - Direction flip first: if bounce_pend, then sq_xdir is inverted before stepping and bounce_pend is cleared.
  - Signed 11-bit step: nx = sq_x ± q_x, ny = sq_y ± q_y, sign taken from direction.
  - Y wall handling, with YMAX = V_ACTIVE - SQ_SIZE (464):
    - ny < 0: ny = -ny, sq_ydir=1.
    - ny > YMAX: ny = 2*YMAX - ny, sq_ydir=0.
    - ny exactly 0 or exactly YMAX: no flip.
  - X miss handling, with XMAX = H_ACTIVE - SQ_SIZE (624):
    - nx < 0 or nx > XMAX: sq_missed=1 for 1 cycle; miss_side=(nx > XMAX).
    - Then sq_x=X_START, sq_y=Y_START, rem_x=rem_y=0, go to WAIT_SERVE.
  - Otherwise: write sq_x=nx, sq_y=ny, go to IDLE, busy=0.
  - Outputs are valid on the cycle after MOVE. Total latency from frame_tick is 3 + max(q_x, q_y) cycles, maximum 12.
- pdl_bounce handling:
  - Sets bounce_pend in any state except WAIT_SERVE.
  - A pulse arriving in the MOVE cycle is folded into that same MOVE.
  - Several pulses within one frame produce one flip.
- State WAIT_SERVE:
  - Position is held at the start point; frame_tick is ignored.
  - serve=1 with freeze=0: sq_xdir=miss_side, bounce_pend=0, go to IDLE.
- freeze=1 in any state (synchronous):
  - Next state is WAIT_SERVE; sq_x and sq_y are set to the start point; rems are cleared; busy=0.
  - Overrides MOVE, including miss detection: no sq_missed pulse.
- frame_tick while busy is dropped; there is no queueing.
- sq_xvel and sq_yvel are sampled only in ACC.
- Changes to sq_xvel mid-update do not affect the frame in progress.

Test Plan:
- Reset then serve=1; three frame_ticks with xvel=yvel=200 -> q sequence 3,3,4; sq_x 312→315→318→322; rem_x 20,40,0.
- sq_yvel=511, sq_ydir=0, sq_y=4, frame_tick -> q_y=8, ny=-4 reflected to sq_y=4, sq_ydir=1; update completes 12 cycles after the tick.
- sq_x=620, xdir=1, xvel=400, frame_tick -> sq_missed pulses once, miss_side=1, position (312,232); frame_ticks ignored until serve, then sq_xdir=1.
- pdl_bounce pulses twice before the tick, xdir=1, sq_x=100, xvel=120 -> one flip, sq_x=98, sq_xdir=0.
- freeze asserted during DIV -> busy=0 next cycle, position (312,232), no sq_missed; frame_tick with freeze=1 ignored.
- rst asserted mid-DIV -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/square_motion.sv
// Square motion: converts px/s speeds to per-frame steps and integrates them into the square's position.
// Latency: 3 + max(q_x, q_y) cycles from an accepted frame_tick (maximum 12); busy is high meanwhile.
// Backpressure: a frame_tick arriving while busy or while waiting for serve is dropped, never queued.
module square_motion #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SQ_SIZE    = 16,
  parameter int FRAME_RATE = 60,
  parameter int X_START    = 312,
  parameter int Y_START    = 232
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [8:0] sq_xvel,
  input  logic [8:0] sq_yvel,
  input  logic       pdl_bounce,
  input  logic       serve,
  input  logic       freeze,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic       sq_xdir,
  output logic       sq_ydir,
  output logic       sq_missed,
  output logic       miss_side,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_WAIT_SERVE,
    ST_IDLE,
    ST_ACC,
    ST_DIV,
    ST_MOVE
  } state_t;

  localparam logic [9:0]         FR      = 10'(FRAME_RATE);
  localparam logic [9:0]         X_ST    = 10'(X_START);
  localparam logic [9:0]         Y_ST    = 10'(Y_START);
  localparam logic signed [10:0] XMAX    = 11'(H_ACTIVE - SQ_SIZE);
  localparam logic signed [10:0] YMAX    = 11'(V_ACTIVE - SQ_SIZE);
  localparam logic signed [10:0] YMAX2   = 11'(2 * (V_ACTIVE - SQ_SIZE));

  state_t     state_q, state_d;
  logic [9:0] sq_x_q, sq_x_d;
  logic [9:0] sq_y_q, sq_y_d;
  logic       xdir_q, xdir_d;
  logic       ydir_q, ydir_d;
  logic       missed_q, missed_d;
  logic       miss_side_q, miss_side_d;
  logic       bounce_pend_q, bounce_pend_d;
  logic [5:0] rem_x_q, rem_x_d;
  logic [5:0] rem_y_q, rem_y_d;
  logic [9:0] sum_x_q, sum_x_d;
  logic [9:0] sum_y_q, sum_y_d;
  logic [3:0] qx_q, qx_d;
  logic [3:0] qy_q, qy_d;

  // MOVE-cycle datapath temporaries
  logic                flip_mv;
  logic                xdir_mv;
  logic                ydir_mv;
  logic signed [10:0]  step_x;
  logic signed [10:0]  step_y;
  logic signed [10:0]  nx;
  logic signed [10:0]  ny;
  logic [9:0]          ny_fix;
  logic                x_out;

  // State and datapath registers, all cleared to the serve position on reset
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT_SERVE;
      sq_x_q        <= X_ST;
      sq_y_q        <= Y_ST;
      xdir_q        <= 1'b1;
      ydir_q        <= 1'b1;
      missed_q      <= 1'b0;
      miss_side_q   <= 1'b1;
      bounce_pend_q <= 1'b0;
      rem_x_q       <= '0;
      rem_y_q       <= '0;
      sum_x_q       <= '0;
      sum_y_q       <= '0;
      qx_q          <= '0;
      qy_q          <= '0;
    end else begin
      state_q       <= state_d;
      sq_x_q        <= sq_x_d;
      sq_y_q        <= sq_y_d;
      xdir_q        <= xdir_d;
      ydir_q        <= ydir_d;
      missed_q      <= missed_d;
      miss_side_q   <= miss_side_d;
      bounce_pend_q <= bounce_pend_d;
      rem_x_q       <= rem_x_d;
      rem_y_q       <= rem_y_d;
      sum_x_q       <= sum_x_d;
      sum_y_q       <= sum_y_d;
      qx_q          <= qx_d;
      qy_q          <= qy_d;
    end
  end

  // Next-state logic: accumulate, divide by repeated subtraction, then step with wall/miss handling
  always_comb begin
    state_d       = state_q;
    sq_x_d        = sq_x_q;
    sq_y_d        = sq_y_q;
    xdir_d        = xdir_q;
    ydir_d        = ydir_q;
    missed_d      = 1'b0;
    miss_side_d   = miss_side_q;
    bounce_pend_d = bounce_pend_q | (pdl_bounce && (state_q != ST_WAIT_SERVE));
    rem_x_d       = rem_x_q;
    rem_y_d       = rem_y_q;
    sum_x_d       = sum_x_q;
    sum_y_d       = sum_y_q;
    qx_d          = qx_q;
    qy_d          = qy_q;

    // A paddle pulse landing in the MOVE cycle itself still counts for this step
    flip_mv = bounce_pend_q | pdl_bounce;
    xdir_mv = flip_mv ? ~xdir_q : xdir_q;
    step_x  = $signed({7'd0, qx_q});
    step_y  = $signed({7'd0, qy_q});
    nx      = xdir_mv ? ($signed({1'b0, sq_x_q}) + step_x) : ($signed({1'b0, sq_x_q}) - step_x);
    ny      = ydir_q  ? ($signed({1'b0, sq_y_q}) + step_y) : ($signed({1'b0, sq_y_q}) - step_y);

    // Reflect off top/bottom walls; landing exactly on a wall keeps the direction
    ny_fix  = ny[9:0];
    ydir_mv = ydir_q;
    if (ny < 11'sd0) begin
      ny_fix  = 10'(-ny);
      ydir_mv = 1'b1;
    end else if (ny > YMAX) begin
      ny_fix  = 10'(YMAX2 - ny);
      ydir_mv = 1'b0;
    end
    x_out = (nx < 11'sd0) || (nx > XMAX);

    case (state_q)
      ST_WAIT_SERVE: begin
        sq_x_d = X_ST;
        sq_y_d = Y_ST;
        if (serve) begin
          xdir_d        = miss_side_q;
          bounce_pend_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (frame_tick) state_d = ST_ACC;
      end
      ST_ACC: begin
        sum_x_d = 10'(rem_x_q) + 10'(sq_xvel);
        sum_y_d = 10'(rem_y_q) + 10'(sq_yvel);
        qx_d    = '0;
        qy_d    = '0;
        state_d = ST_DIV;
      end
      ST_DIV: begin
        if ((sum_x_q < FR) && (sum_y_q < FR)) begin
          state_d = ST_MOVE;
        end else begin
          if (sum_x_q >= FR) begin
            sum_x_d = sum_x_q - FR;
            qx_d    = qx_q + 4'd1;
          end
          if (sum_y_q >= FR) begin
            sum_y_d = sum_y_q - FR;
            qy_d    = qy_q + 4'd1;
          end
        end
      end
      ST_MOVE: begin
        rem_x_d       = sum_x_q[5:0];
        rem_y_d       = sum_y_q[5:0];
        xdir_d        = xdir_mv;
        ydir_d        = ydir_mv;
        bounce_pend_d = 1'b0;
        if (x_out) begin
          missed_d    = 1'b1;
          miss_side_d = (nx > XMAX);
          sq_x_d      = X_ST;
          sq_y_d      = Y_ST;
          rem_x_d     = '0;
          rem_y_d     = '0;
          state_d     = ST_WAIT_SERVE;
        end else begin
          sq_x_d  = nx[9:0];
          sq_y_d  = ny_fix;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_SERVE;
    endcase

    // Freeze parks the square and wins over everything, including a miss in MOVE
    if (freeze) begin
      state_d     = ST_WAIT_SERVE;
      sq_x_d      = X_ST;
      sq_y_d      = Y_ST;
      rem_x_d     = '0;
      rem_y_d     = '0;
      missed_d    = 1'b0;
      xdir_d      = xdir_q;
      ydir_d      = ydir_q;
      miss_side_d = miss_side_q;
    end
  end

  assign sq_x      = sq_x_q;
  assign sq_y      = sq_y_q;
  assign sq_xdir   = xdir_q;
  assign sq_ydir   = ydir_q;
  assign sq_missed = missed_q;
  assign miss_side = miss_side_q;
  assign busy      = (state_q == ST_ACC) || (state_q == ST_DIV) || (state_q == ST_MOVE);

endmodule

// File: tb/tb_square_motion.sv
// Directed bench for square_motion: serve, integration, wall reflection, misses, paddle flip, freeze, async reset.
// Inputs are driven 1 ns after the rising edge and outputs are sampled there too.
// Every frame wait is bounded; an expired bound is reported and counted as a failure.
module tb_square_motion;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [8:0] sq_xvel = '0;
  logic [8:0] sq_yvel = '0;
  logic       pdl_bounce = 1'b0;
  logic       serve = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] sq_x;
  logic [9:0] sq_y;
  logic       sq_xdir;
  logic       sq_ydir;
  logic       sq_missed;
  logic       miss_side;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int nm;

  square_motion dut (
    .clk_0      (clk_0),
    .rst        (rst),
    .frame_tick (frame_tick),
    .sq_xvel    (sq_xvel),
    .sq_yvel    (sq_yvel),
    .pdl_bounce (pdl_bounce),
    .serve      (serve),
    .freeze     (freeze),
    .sq_x       (sq_x),
    .sq_y       (sq_y),
    .sq_xdir    (sq_xdir),
    .sq_ydir    (sq_ydir),
    .sq_missed  (sq_missed),
    .miss_side  (miss_side),
    .busy       (busy)
  );

  always #20 clk_0 = ~clk_0;

  task automatic apply_reset();
    @(posedge clk_0); #1;
    rst = 1'b1;
    #4;
    rst = 1'b0;
    @(posedge clk_0); #1;
  endtask

  task automatic pulse_serve();
    serve = 1'b1;
    @(posedge clk_0); #1;
    serve = 1'b0;
  endtask

  task automatic pulse_pdl();
    pdl_bounce = 1'b1;
    @(posedge clk_0); #1;
    pdl_bounce = 1'b0;
  endtask

  // One frame: tick, then count edges until busy drops; nmiss counts sq_missed samples incl. one extra cycle
  task automatic do_frame(input logic [8:0] xv, input logic [8:0] yv, output int l, output int nmiss);
    sq_xvel = xv;
    sq_yvel = yv;
    frame_tick = 1'b1;
    @(posedge clk_0); #1;
    frame_tick = 1'b0;
    l = 0;
    nmiss = 0;
    while (busy && l < 40) begin
      @(posedge clk_0); #1;
      l++;
      nmiss += int'(sq_missed);
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: busy still %0b after %0d cycles, required 0", busy, l);
    end
    @(posedge clk_0); #1;
    nmiss += int'(sq_missed);
  endtask

  task automatic walk(input int n, input logic [8:0] xv, input logic [8:0] yv, output int tot_miss);
    int l, m;
    tot_miss = 0;
    for (int i = 0; i < n; i++) begin
      do_frame(xv, yv, l, m);
      tot_miss += m;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #5;
    n_checks++; if (sq_x !== 10'd312) begin n_fail++; $display("FAIL reset_x: got %0d, required 312", sq_x); end
    n_checks++; if (sq_y !== 10'd232) begin n_fail++; $display("FAIL reset_y: got %0d, required 232", sq_y); end
    n_checks++; if ({sq_xdir, sq_ydir, sq_missed, miss_side, busy} !== 5'b11010) begin
      n_fail++; $display("FAIL reset_flags: xdir,ydir,missed,side,busy got %b, required 11010",
                         {sq_xdir, sq_ydir, sq_missed, miss_side, busy});
    end
    @(posedge clk_0); #1;
    rst = 1'b0;
    @(posedge clk_0); #1;
  endtask

  task automatic test_integrate();
    pulse_serve();
    n_checks++; if (sq_xdir !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL serve_dir: xdir %b busy %b, required 1 0", sq_xdir, busy);
    end
    do_frame(9'd200, 9'd200, lat, nm);
    n_checks++; if (sq_x !== 10'd315 || sq_y !== 10'd235 || lat != 6) begin
      n_fail++; $display("FAIL int_f1: x %0d y %0d lat %0d, required 315 235 6", sq_x, sq_y, lat);
    end
    do_frame(9'd200, 9'd200, lat, nm);
    n_checks++; if (sq_x !== 10'd318 || sq_y !== 10'd238 || lat != 6) begin
      n_fail++; $display("FAIL int_f2: x %0d y %0d lat %0d, required 318 238 6", sq_x, sq_y, lat);
    end
    do_frame(9'd200, 9'd200, lat, nm);
    n_checks++; if (sq_x !== 10'd322 || sq_y !== 10'd242 || lat != 7) begin
      n_fail++; $display("FAIL int_f3: x %0d y %0d lat %0d, required 322 242 7", sq_x, sq_y, lat);
    end
  endtask

  task automatic test_wall_reflect();
    apply_reset();
    pulse_serve();
    walk(29, 9'd0, 9'd480, nm);
    n_checks++; if (sq_y !== 10'd464 || sq_ydir !== 1'b1) begin
      n_fail++; $display("FAIL ymax_exact: y %0d ydir %b, required 464 1", sq_y, sq_ydir);
    end
    do_frame(9'd0, 9'd480, lat, nm);
    n_checks++; if (sq_y !== 10'd456 || sq_ydir !== 1'b0) begin
      n_fail++; $display("FAIL bottom_bounce: y %0d ydir %b, required 456 0", sq_y, sq_ydir);
    end
    walk(56, 9'd0, 9'd480, nm);
    do_frame(9'd30, 9'd240, lat, nm);
    n_checks++; if (sq_y !== 10'd4 || sq_x !== 10'd312 || lat != 7) begin
      n_fail++; $display("FAIL walk_up: y %0d x %0d lat %0d, required 4 312 7", sq_y, sq_x, lat);
    end
    do_frame(9'd511, 9'd511, lat, nm);
    n_checks++; if (sq_y !== 10'd4 || sq_ydir !== 1'b1 || sq_x !== 10'd321) begin
      n_fail++; $display("FAIL top_bounce: y %0d ydir %b x %0d, required 4 1 321", sq_y, sq_ydir, sq_x);
    end
    n_checks++; if (lat != 12) begin
      n_fail++; $display("FAIL max_latency: got %0d cycles, required 12", lat);
    end
  endtask

  task automatic test_miss_right();
    apply_reset();
    pulse_serve();
    walk(38, 9'd480, 9'd0, nm);
    do_frame(9'd240, 9'd0, lat, nm);
    n_checks++; if (sq_x !== 10'd620) begin
      n_fail++; $display("FAIL pre_miss_x: got %0d, required 620", sq_x);
    end
    do_frame(9'd400, 9'd0, lat, nm);
    n_checks++; if (nm != 1 || miss_side !== 1'b1 || lat != 9) begin
      n_fail++; $display("FAIL miss_right: pulses %0d side %b lat %0d, required 1 1 9", nm, miss_side, lat);
    end
    n_checks++; if (sq_x !== 10'd312 || sq_y !== 10'd232) begin
      n_fail++; $display("FAIL miss_restart: x %0d y %0d, required 312 232", sq_x, sq_y);
    end
    frame_tick = 1'b1;
    @(posedge clk_0); #1;
    frame_tick = 1'b0;
    n_checks++; if (busy !== 1'b0 || sq_x !== 10'd312) begin
      n_fail++; $display("FAIL tick_in_wait: busy %b x %0d, required 0 312", busy, sq_x);
    end
    pulse_serve();
    n_checks++; if (sq_xdir !== 1'b1) begin
      n_fail++; $display("FAIL serve_right: xdir %b, required 1", sq_xdir);
    end
  endtask

  task automatic test_miss_left();
    pulse_pdl();
    do_frame(9'd480, 9'd0, lat, nm);
    n_checks++; if (sq_x !== 10'd304 || sq_xdir !== 1'b0) begin
      n_fail++; $display("FAIL flip_left: x %0d xdir %b, required 304 0", sq_x, sq_xdir);
    end
    walk(38, 9'd480, 9'd0, nm);
    n_checks++; if (sq_x !== 10'd0 || nm != 0) begin
      n_fail++; $display("FAIL x_zero_edge: x %0d pulses %0d, required 0 0", sq_x, nm);
    end
    do_frame(9'd480, 9'd0, lat, nm);
    n_checks++; if (nm != 1 || miss_side !== 1'b0 || sq_x !== 10'd312) begin
      n_fail++; $display("FAIL miss_left: pulses %0d side %b x %0d, required 1 0 312", nm, miss_side, sq_x);
    end
    pulse_serve();
    n_checks++; if (sq_xdir !== 1'b0) begin
      n_fail++; $display("FAIL serve_left: xdir %b, required 0", sq_xdir);
    end
  endtask

  task automatic test_paddle_bounce();
    walk(26, 9'd480, 9'd0, nm);
    do_frame(9'd240, 9'd0, lat, nm);
    pulse_pdl();
    do_frame(9'd0, 9'd0, lat, nm);
    n_checks++; if (sq_x !== 10'd100 || sq_xdir !== 1'b1 || lat != 3) begin
      n_fail++; $display("FAIL pdl_setup: x %0d xdir %b lat %0d, required 100 1 3", sq_x, sq_xdir, lat);
    end
    pulse_pdl();
    @(posedge clk_0); #1;
    pulse_pdl();
    do_frame(9'd120, 9'd0, lat, nm);
    n_checks++; if (sq_x !== 10'd98 || sq_xdir !== 1'b0) begin
      n_fail++; $display("FAIL pdl_double: x %0d xdir %b, required 98 0", sq_x, sq_xdir);
    end
  endtask

  task automatic test_freeze();
    int m;
    sq_xvel = 9'd480;
    sq_yvel = 9'd0;
    frame_tick = 1'b1;
    @(posedge clk_0); #1;
    frame_tick = 1'b0;
    @(posedge clk_0); #1;
    freeze = 1'b1;
    @(posedge clk_0); #1;
    n_checks++; if (busy !== 1'b0 || sq_x !== 10'd312 || sq_y !== 10'd232) begin
      n_fail++; $display("FAIL freeze_div: busy %b x %0d y %0d, required 0 312 232", busy, sq_x, sq_y);
    end
    m = int'(sq_missed);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_0); #1;
      m += int'(sq_missed);
    end
    frame_tick = 1'b1;
    @(posedge clk_0); #1;
    frame_tick = 1'b0;
    n_checks++; if (m != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL freeze_hold: pulses %0d busy %b, required 0 0", m, busy);
    end
    freeze = 1'b0;
    pulse_serve();
  endtask

  task automatic test_async_reset();
    do_frame(9'd120, 9'd120, lat, nm);
    n_checks++; if (sq_x !== 10'd310 || sq_y !== 10'd234) begin
      n_fail++; $display("FAIL pre_rst_move: x %0d y %0d, required 310 234", sq_x, sq_y);
    end
    sq_xvel = 9'd480;
    sq_yvel = 9'd480;
    frame_tick = 1'b1;
    @(posedge clk_0); #1;
    frame_tick = 1'b0;
    @(posedge clk_0); #1;
    rst = 1'b1;
    #2;
    n_checks++; if (sq_x !== 10'd312 || sq_y !== 10'd232 ||
                    {sq_xdir, sq_ydir, sq_missed, miss_side, busy} !== 5'b11010) begin
      n_fail++; $display("FAIL async_rst: x %0d y %0d flags %b, required 312 232 11010",
                         sq_x, sq_y, {sq_xdir, sq_ydir, sq_missed, miss_side, busy});
    end
    @(posedge clk_0); #1;
    rst = 1'b0;
    @(posedge clk_0); #1;
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_wall_reflect();
    test_miss_right();
    test_miss_left();
    test_paddle_bounce();
    test_freeze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
